// File: rtl/sys_pkg.sv
// Shared types and width helpers for the systolic array datapath
// (feeder, rows, drain, accumulator).
package sys_pkg;

    localparam int SYS_COL_DEF    = 16;
    localparam int DATA_WIDTH_DEF = 16;

    function automatic int psum_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Occupancy counters must reach the full depth, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Aligned result vector for the default array geometry.
    typedef logic [psum_width(DATA_WIDTH_DEF)-1:0] sys_vec_t [SYS_COL_DEF];

endpackage

// File: rtl/sys_skew_line.sv
// One column's delay pipeline (data plus valid) used to undo the array's
// diagonal skew; DEPTH=0 degenerates to a wire.
module sys_skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctrl_s;
            assign unused_ctrl_s = clk ^ rstn ^ clear;
            assign vld_out       = vld_in;
            assign data_out      = data_in;
        end else begin : g_pipe
            logic [DEPTH-1:0] vld_q;
            logic [DEPTH-1:0] vld_d;
            logic [DEPTH:0]   vld_src_s;
            logic [WIDTH-1:0] data_q   [DEPTH];
            logic [WIDTH-1:0] data_d   [DEPTH];
            logic [WIDTH-1:0] data_src_s [DEPTH+1];

            // Stage k is fed by stage k-1, stage 0 by the column input.
            always_comb begin
                vld_src_s     = {vld_q, vld_in};
                data_src_s[0] = data_in;
                for (int k = 0; k < DEPTH; k++) begin
                    data_src_s[k+1] = data_q[k];
                end
            end

            // Valids shift (flushed by clear); data only moves with a valid.
            always_comb begin
                for (int k = 0; k < DEPTH; k++) begin
                    vld_d[k]  = clear ? 1'b0 : vld_src_s[k];
                    data_d[k] = vld_src_s[k] ? data_src_s[k] : data_q[k];
                end
            end

            // Pipeline state registers.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    vld_q <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        data_q[k] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    for (int k = 0; k < DEPTH; k++) begin
                        data_q[k] <= data_d[k];
                    end
                end
            end

            assign vld_out  = vld_q[DEPTH-1];
            assign data_out = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sys_drain.sv
// Drain end of the systolic array: de-skews the last row's psums into aligned
// vectors and buffers them in a FIFO that flags (never back-pressures) overflow.
module sys_drain
    import sys_pkg::*;
#(
    parameter int  SYS_COL    = 16,
    parameter int  DATA_WIDTH = 16,
    parameter int  FIFO_DEPTH = 8,
    localparam int PSUM_WIDTH = psum_width(DATA_WIDTH),
    localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic [SYS_COL-1:0]    psum_vld_in,
    input  logic [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PSUM_WIDTH-1:0] out_data [0:SYS_COL-1],
    output logic [CNT_W-1:0]      out_count,
    output logic                  overflow,
    output logic                  skew_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [PSUM_WIDTH-1:0] vec_t [SYS_COL];

    logic [SYS_COL-1:0] dly_vld_s;
    vec_t               dly_data_s;

    // Column i lags column 0 by i cycles, so it gets SYS_COL-1-i stages.
    generate
        for (genvar i = 0; i < SYS_COL; i++) begin : g_col
            sys_skew_line #(
                .DEPTH (SYS_COL - 1 - i),
                .WIDTH (PSUM_WIDTH)
            ) u_skew_line (
                .clk      (clk),
                .rstn     (rstn),
                .clear    (clear),
                .vld_in   (psum_vld_in[i]),
                .data_in  (psum_in[i]),
                .vld_out  (dly_vld_s[i]),
                .data_out (dly_data_s[i])
            );
        end
    endgenerate

    vec_t             mem_q [FIFO_DEPTH];
    vec_t             mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic             skew_err_q, skew_err_d;

    logic push_s, pop_s, full_s, accept_s, misalign_s;

    // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        push_s     = dly_vld_s[0];
        misalign_s = |(dly_vld_s ^ {SYS_COL{push_s}});
        full_s     = (count_q == CNT_W'(FIFO_DEPTH));
        pop_s      = out_valid_q && out_ready;
        accept_s   = push_s && (!full_s || pop_s);
    end

    // FIFO and sticky-flag next state; clear overrides push and pop.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        skew_err_d  = skew_err_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            skew_err_d  = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (accept_s) begin
                mem_d[wr_ptr_q] = dly_data_s;
                wr_ptr_d        = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d     = count_q + CNT_W'(accept_s) - CNT_W'(pop_s);
            overflow_d  = overflow_q | (push_s & full_s & ~pop_s);
            skew_err_d  = skew_err_q | misalign_s;
            out_valid_d = (count_d != '0);
        end
    end

    // FIFO storage, pointers and status registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_q[e] <= '{default: '0};
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            skew_err_q  <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            skew_err_q  <= skew_err_d;
        end
    end

    // Head of the FIFO is always visible on out_data.
    always_comb begin
        for (int c = 0; c < SYS_COL; c++) begin
            out_data[c] = mem_q[rd_ptr_q][c];
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = count_q;
    assign overflow  = overflow_q;
    assign skew_err  = skew_err_q;

endmodule

// File: doc/sys_drain.md
Name: sys_drain

Overview:
- Drain end of the systolic array: sits below the last sys_row and collects its diagonally skewed psum outputs.
- Column i of a result row arrives one cycle after column i-1, qualified by that column's enable bit from the last row.
- De-skews each result into an aligned SYS_COL-wide vector and buffers it in a FIFO.
- Presents vectors on a valid/ready interface to the writeback/accumulator logic. The array cannot stall, so buffer overflow is flagged, not back-pressured.

Parameters:
- SYS_COL, 16, number of array columns.
- DATA_WIDTH, 16, operand width; PSUM_WIDTH = 2*DATA_WIDTH, localparam.
- FIFO_DEPTH, 8, aligned vectors buffered; power of two, at least 2.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of all state.
- psum_vld_in  input  SYS_COL  per-column valid; the last row's en_out.
- psum_in  input  PSUM_WIDTH x [0:SYS_COL-1]  per-column psum from the last row.
- out_valid  output  1  aligned vector available.
- out_ready  input  1  consumer accepts the vector.
- out_data  output  PSUM_WIDTH x [0:SYS_COL-1]  aligned vector; column 0 at index 0.
- out_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  output  1  sticky: a vector was dropped.
- skew_err  output  1  sticky: the column valids did not line up.

Behaviour:
- Reset (rstn low, async): out_valid=0, out_count=0, overflow=0, skew_err=0, out_data=0, all delay-line valids=0, FIFO pointers=0.
- De-skew: column i passes through SYS_COL-1-i register stages, data plus valid; column SYS_COL-1 has 0 stages. Data registers load only when their valid is high.
- Alignment: if column 0 is valid in cycle c, every column presents at the skew output in cycle c+SYS_COL-1.
- Aligned valid is the delayed valid of column 0 (push).
- If any delayed column valid differs from push in a cycle, skew_err is set on the next edge. The vector is still pushed when push=1.
- FIFO write happens at the edge ending cycle c+SYS_COL-1.
- If the FIFO was empty, out_valid=1 in cycle c+SYS_COL. Total latency from column 0 is SYS_COL cycles; from column SYS_COL-1 it is 1 cycle.
- Pop = out_valid && out_ready. out_data always shows the FIFO head and is stable while out_valid && !out_ready.
- Back-to-back rows (column 0 valid every cycle) give one push per cycle. Throughput is 1 vector/cycle when out_ready=1.
- Full without pop: the push is dropped, overflow is set, occupancy and contents are unchanged.
- Full with pop: the push is accepted and occupancy stays FIFO_DEPTH.
- Empty with push: out_valid rises the next cycle. There is no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH. out_count goes from 0 to FIFO_DEPTH inclusive.
- clear has priority over push and pop in its cycle. It zeroes pointers, count, delay-line valids, overflow and skew_err; data registers are left as is.
- out_valid=0 in the cycle after clear.
- In-flight partial rows are discarded by clear.
- Reset asserted mid-operation discards everything immediately, asynchronously.
- No arithmetic is performed on psums; widths pass through unchanged.

Decomposition:
- sys_pkg holds:
  - psum_width(DATA_WIDTH) function;
  - count-width helper;
  - sys_vec_t parameterised aligned-vector typedef, shared with the feeder and accumulator.
- Sub-module sys_skew_line(DEPTH, WIDTH): one column's delay pipeline of data plus valid. DEPTH=0 is a pass-through.
- The generate loop instantiates one sys_skew_line per column. The FIFO is inline in sys_drain.

Test Plan (SYS_COL=4, DATA_WIDTH=16, FIFO_DEPTH=4):
- Single row:
  - stimulus: column i valid in cycle 10+i with psum=0x100+i;
  - response: out_valid=1 first in cycle 14, out_data={0x100,0x101,0x102,0x103}, out_count=1, skew_err=0.
- Streaming:
  - stimulus: 6 consecutive skewed rows with out_ready=1;
  - response: 6 vectors in 6 consecutive cycles, in order, no overflow.
- Overflow:
  - stimulus: out_ready=0, push 5 rows;
  - response: out_count=4, overflow=1, rows 0-3 retained; popping returns rows 0-3 only.
- Full plus simultaneous pop:
  - stimulus: FIFO full, out_ready=1 in the same cycle as a push;
  - response: out_count stays 4, overflow=0, new row appears last.
- Skew error:
  - stimulus: column 2 valid one cycle late;
  - response: skew_err=1 the cycle after alignment, and the sticky flag holds until clear.
- Clear and reset:
  - stimulus: clear asserted while 2 vectors are buffered and a row is half in flight;
  - response: out_valid=0 and out_count=0 next cycle, flags cleared, no vector emitted from the partial row.
  - stimulus: rstn pulsed low mid-row;
  - response: same empty state, asynchronously.
